// File: rtl/vec_alu_seq_pkg.sv
// Shared opcode constants, FSM encoding and small helpers for the vector ALU sequencer.
// Imported by the interface, the element-wise ALU and the top-level sequencer.
package vec_alu_seq_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
   localparam logic [OP_W-1:0] OP_REPL = 3'b010;
   localparam logic [OP_W-1:0] OP_MUL  = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // MUL is the only opcode that takes the multi-cycle element-serial path
   function automatic logic isMul(input logic [OP_W-1:0] op);
      return op == OP_MUL;
   endfunction

   function automatic state_t stateAfterAccept(input logic [OP_W-1:0] op);
      return isMul(op) ? ST_EXEC : ST_RESP;
   endfunction

endpackage

// File: rtl/vec_alu_seq_if.sv
// Command/response bundle between a requester and the vector ALU sequencer.
// The master side issues commands and drains responses; the slave side is the sequencer.
interface vec_alu_seq_if
   import vec_alu_seq_pkg::*;
#(
   parameter int REG_WIDTH = 256
);

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [REG_WIDTH-1:0] cmd_a;
   logic [REG_WIDTH-1:0] cmd_b;
   logic                 cmd_use_imm;
   logic [OP_W-1:0]      cmd_op;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [REG_WIDTH-1:0] rsp_result;
   logic                 rsp_zero;

   logic                 busy;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_use_imm, cmd_op, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_result, rsp_zero, busy
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_use_imm, cmd_op, rsp_ready,
      output cmd_ready, rsp_valid, rsp_result, rsp_zero, busy
   );

endinterface

// File: rtl/vec_alu_seq_alu.sv
// Combinational element-wise ALU for the single-cycle opcodes (ADD, SUB, REPL).
// MUL and reserved opcodes yield zero here; the sequencer supplies MUL results itself.
module vec_alu_seq_alu
   import vec_alu_seq_pkg::*;
#(
   parameter int ELEM_WIDTH = 32,
   parameter int NUM_ELEM   = 8
) (
   input  logic [NUM_ELEM*ELEM_WIDTH-1:0] i_a,
   input  logic [NUM_ELEM*ELEM_WIDTH-1:0] i_b,
   input  logic [OP_W-1:0]                i_op,
   output logic [NUM_ELEM*ELEM_WIDTH-1:0] o_result
);

   // Each lane is independent so carries and borrows never reach a neighbour
   for (genvar g = 0; g < NUM_ELEM; g++) begin : g_lane
      logic [ELEM_WIDTH-1:0] w_a;
      logic [ELEM_WIDTH-1:0] w_b;
      logic [ELEM_WIDTH-1:0] w_res;

      assign w_a = i_a[g*ELEM_WIDTH +: ELEM_WIDTH];
      assign w_b = i_b[g*ELEM_WIDTH +: ELEM_WIDTH];

      always_comb begin
         w_res = '0;
         case (i_op)
            OP_ADD:  w_res = w_a + w_b;
            OP_SUB:  w_res = w_a - w_b;
            OP_REPL: w_res = w_b;
            default: w_res = '0;
         endcase
      end

      assign o_result[g*ELEM_WIDTH +: ELEM_WIDTH] = w_res;
   end

endmodule

// File: rtl/vec_alu_seq.sv
// Vector ALU sequencer: accepts one command at a time, runs ADD/SUB/REPL in one cycle
// through the shared ALU and MUL one element per cycle, then holds the response until drained.
module vec_alu_seq
   import vec_alu_seq_pkg::*;
#(
   parameter int REG_WIDTH  = 256,
   parameter int ELEM_WIDTH = 32,
   parameter int NUM_ELEM   = 8
) (
   input  logic          clk,
   input  logic          rst,
   vec_alu_seq_if.slave  bus
);

   localparam int             CNT_W     = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
   localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(NUM_ELEM - 1);

   state_t                r_state;
   state_t                w_nextState;

   logic [REG_WIDTH-1:0]  r_a;
   logic [REG_WIDTH-1:0]  r_b;
   logic [OP_W-1:0]       r_op;
   logic [CNT_W-1:0]      r_cnt;
   logic [REG_WIDTH-1:0]  r_mul;

   logic [REG_WIDTH-1:0]  w_bEff;
   logic [REG_WIDTH-1:0]  w_aluResult;
   logic [REG_WIDTH-1:0]  w_result;
   logic [ELEM_WIDTH-1:0] w_elemA;
   logic [ELEM_WIDTH-1:0] w_elemB;
   logic [ELEM_WIDTH-1:0] w_prod;

   logic                  w_cmdReady;
   logic                  w_rspValid;
   logic                  w_busy;
   logic                  w_accept;
   logic                  w_lastElem;

   // The immediate is folded into B at capture, so the datapath never sees use_imm again
   assign w_bEff     = bus.cmd_use_imm ? {NUM_ELEM{bus.cmd_b[ELEM_WIDTH-1:0]}} : bus.cmd_b;
   assign w_accept   = bus.cmd_valid & w_cmdReady;
   assign w_lastElem = (r_cnt == LAST_ELEM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // RESP may hand straight over to the next command on the retiring edge
   always_comb begin
      w_nextState = r_state;
      w_cmdReady  = 1'b0;
      w_rspValid  = 1'b0;
      w_busy      = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_busy     = 1'b0;
            w_cmdReady = 1'b1;
            if (bus.cmd_valid) begin
               w_nextState = stateAfterAccept(bus.cmd_op);
            end
         end
         ST_EXEC: begin
            if (w_lastElem) begin
               w_nextState = ST_RESP;
            end
         end
         ST_RESP: begin
            w_rspValid = 1'b1;
            w_cmdReady = bus.rsp_ready;
            if (bus.rsp_ready) begin
               w_nextState = bus.cmd_valid ? stateAfterAccept(bus.cmd_op) : ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_elemA = '0;
      w_elemB = '0;
      for (int i = 0; i < NUM_ELEM; i++) begin
         if (r_cnt == CNT_W'(i)) begin
            w_elemA = r_a[i*ELEM_WIDTH +: ELEM_WIDTH];
            w_elemB = r_b[i*ELEM_WIDTH +: ELEM_WIDTH];
         end
      end
   end

   assign w_prod = w_elemA * w_elemB;

   // Operands only change on acceptance, which keeps the response stable under backpressure
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_op  <= OP_ADD;
         r_cnt <= '0;
         r_mul <= '0;
      end else if (w_accept) begin
         r_a   <= bus.cmd_a;
         r_b   <= w_bEff;
         r_op  <= bus.cmd_op;
         r_cnt <= '0;
      end else if (r_state == ST_EXEC) begin
         for (int i = 0; i < NUM_ELEM; i++) begin
            if (r_cnt == CNT_W'(i)) begin
               r_mul[i*ELEM_WIDTH +: ELEM_WIDTH] <= w_prod;
            end
         end
         r_cnt <= w_lastElem ? '0 : r_cnt + CNT_W'(1);
      end
   end

   vec_alu_seq_alu #(
      .ELEM_WIDTH (ELEM_WIDTH),
      .NUM_ELEM   (NUM_ELEM)
   ) u_alu (
      .i_a      (r_a),
      .i_b      (r_b),
      .i_op     (r_op),
      .o_result (w_aluResult)
   );

   assign w_result = isMul(r_op) ? r_mul : w_aluResult;

   assign bus.cmd_ready  = w_cmdReady;
   assign bus.rsp_valid  = w_rspValid;
   assign bus.busy       = w_busy;
   assign bus.rsp_result = w_result;
   assign bus.rsp_zero   = ~|w_result;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Directed self-checking bench for vec_alu_seq at default geometry (8 x 32-bit lanes).
// Each scenario task drives its own stimulus and compares against hand-computed vectors.
module tb_vec_alu_seq;
   import vec_alu_seq_pkg::*;

   localparam int EW = 32;
   localparam int NE = 8;
   localparam int RW = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int nCompared   = 0;
   int nMismatched = 0;

   logic [RW-1:0] vecA;
   logic [RW-1:0] vecB;

   vec_alu_seq_if #(.REG_WIDTH(RW)) bus ();

   vec_alu_seq #(
      .REG_WIDTH  (RW),
      .ELEM_WIDTH (EW),
      .NUM_ELEM   (NE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [RW-1:0] mk(input logic [31:0] e7, e6, e5, e4, e3, e2, e1, e0);
      return {e7, e6, e5, e4, e3, e2, e1, e0};
   endfunction

   function automatic logic [RW-1:0] splat(input logic [31:0] e);
      return {NE{e}};
   endfunction

   // Present a command at the falling edge, let it be taken on the next rising edge, then scramble inputs
   task automatic issueCmd(input logic [RW-1:0] a, input logic [RW-1:0] b,
                           input logic useImm, input logic [2:0] op);
      @(negedge clk);
      bus.cmd_a       = a;
      bus.cmd_b       = b;
      bus.cmd_use_imm = useImm;
      bus.cmd_op      = op;
      bus.cmd_valid   = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_a       = '1;
      bus.cmd_b       = '1;
      bus.cmd_use_imm = 1'b0;
      bus.cmd_op      = OP_SUB;
   endtask

   task automatic waitRsp(output int lat, output logic readyStayedLow);
      lat            = 1;
      readyStayedLow = 1'b1;
      while (bus.rsp_valid !== 1'b1 && lat < 40) begin
         if (bus.cmd_ready !== 1'b0) readyStayedLow = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic retire();
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      nCompared++; if (bus.rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.rsp_valid); end
      nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
      nCompared++; if (bus.rsp_result !== '0) begin nMismatched++; $display("[TB] FAIL reset_result: got %h expected 0", bus.rsp_result); end
      nCompared++; if (bus.rsp_zero !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_zero: got %b expected 1", bus.rsp_zero); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      nCompared++; if (bus.cmd_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.cmd_ready); end
   endtask

   task automatic test_add();
      logic [RW-1:0] expV;
      int            lat;
      logic          rdyLow;
      expV = mk(88, 77, 66, 55, 44, 33, 22, 11);
      issueCmd(vecA, vecB, 1'b0, OP_ADD);
      waitRsp(lat, rdyLow);
      nCompared++; if (lat !== 1) begin nMismatched++; $display("[TB] FAIL add_latency: got %0d expected 1", lat); end
      nCompared++; if (bus.rsp_result !== expV) begin nMismatched++; $display("[TB] FAIL add_result: got %h expected %h", bus.rsp_result, expV); end
      nCompared++; if (bus.rsp_zero !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_zero: got %b expected 0", bus.rsp_zero); end
      nCompared++; if (bus.busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL add_busy: got %b expected 1", bus.busy); end
      nCompared++; if (bus.cmd_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_ready_resp: got %b expected 0", bus.cmd_ready); end
      retire();
      nCompared++; if (bus.rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_retired_valid: got %b expected 0", bus.rsp_valid); end
      nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_retired_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_mul();
      logic [RW-1:0] expV;
      logic [RW-1:0] a2;
      logic [RW-1:0] b2;
      int            lat;
      logic          rdyLow;
      expV = mk(640, 490, 360, 250, 160, 90, 40, 10);
      issueCmd(vecA, vecB, 1'b0, OP_MUL);
      waitRsp(lat, rdyLow);
      nCompared++; if (lat !== 9) begin nMismatched++; $display("[TB] FAIL mul_latency: got %0d expected 9", lat); end
      nCompared++; if (rdyLow !== 1'b1) begin nMismatched++; $display("[TB] FAIL mul_ready_exec: got %b expected 1 (ready low throughout)", rdyLow); end
      nCompared++; if (bus.rsp_result !== expV) begin nMismatched++; $display("[TB] FAIL mul_result: got %h expected %h", bus.rsp_result, expV); end
      retire();
      // Lane products that overflow 32 bits must keep only their low word
      a2   = mk(32'h0001_0000, 32'hFFFF_FFFF, 3, 0, 7, 32'h8000_0000, 1, 32'h0000_FFFF);
      b2   = mk(32'h0001_0000, 2, 32'hFFFF_FFFF, 123, 6, 2, 1, 32'h0000_FFFF);
      expV = mk(0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 32'h2A, 0, 1, 32'hFFFE_0001);
      issueCmd(a2, b2, 1'b0, OP_MUL);
      waitRsp(lat, rdyLow);
      nCompared++; if (bus.rsp_result !== expV) begin nMismatched++; $display("[TB] FAIL mul_wrap_result: got %h expected %h", bus.rsp_result, expV); end
      retire();
   endtask

   task automatic test_sub_imm();
      int   lat;
      logic rdyLow;
      issueCmd(splat(5), splat(5), 1'b1, OP_SUB);
      waitRsp(lat, rdyLow);
      nCompared++; if (bus.rsp_result !== '0) begin nMismatched++; $display("[TB] FAIL subimm_result: got %h expected 0", bus.rsp_result); end
      nCompared++; if (bus.rsp_zero !== 1'b1) begin nMismatched++; $display("[TB] FAIL subimm_zero: got %b expected 1", bus.rsp_zero); end
      retire();
      issueCmd(splat(5), mk(9, 9, 9, 9, 9, 9, 9, 5), 1'b1, OP_SUB);
      waitRsp(lat, rdyLow);
      nCompared++; if (bus.rsp_result !== '0) begin nMismatched++; $display("[TB] FAIL subimm_repl_result: got %h expected 0", bus.rsp_result); end
      retire();
   endtask

   task automatic test_wrap();
      logic [RW-1:0] expV;
      int            lat;
      logic          rdyLow;
      expV = mk(0, 0, 0, 0, 0, 0, 7, 0);
      issueCmd(mk(0, 0, 0, 0, 0, 0, 3, 32'hFFFF_FFFF), mk(0, 0, 0, 0, 0, 0, 4, 1), 1'b0, OP_ADD);
      waitRsp(lat, rdyLow);
      nCompared++; if (bus.rsp_result !== expV) begin nMismatched++; $display("[TB] FAIL add_wrap_result: got %h expected %h", bus.rsp_result, expV); end
      retire();
      expV = mk(0, 0, 0, 0, 0, 0, 3, 32'hFFFF_FFFF);
      issueCmd(mk(0, 0, 0, 0, 0, 0, 5, 0), mk(0, 0, 0, 0, 0, 0, 2, 1), 1'b0, OP_SUB);
      waitRsp(lat, rdyLow);
      nCompared++; if (bus.rsp_result !== expV) begin nMismatched++; $display("[TB] FAIL sub_wrap_result: got %h expected %h", bus.rsp_result, expV); end
      retire();
   endtask

   task automatic test_repl_reserved();
      int   lat;
      logic rdyLow;
      issueCmd(vecA, vecB, 1'b0, OP_REPL);
      waitRsp(lat, rdyLow);
      nCompared++; if (bus.rsp_result !== vecB) begin nMismatched++; $display("[TB] FAIL repl_result: got %h expected %h", bus.rsp_result, vecB); end
      retire();
      issueCmd(vecA, vecB, 1'b0, 3'b101);
      waitRsp(lat, rdyLow);
      nCompared++; if (lat !== 1) begin nMismatched++; $display("[TB] FAIL reserved_latency: got %0d expected 1", lat); end
      nCompared++; if (bus.rsp_result !== '0) begin nMismatched++; $display("[TB] FAIL reserved_result: got %h expected 0", bus.rsp_result); end
      nCompared++; if (bus.rsp_zero !== 1'b1) begin nMismatched++; $display("[TB] FAIL reserved_zero: got %b expected 1", bus.rsp_zero); end
      retire();
   endtask

   task automatic test_back_to_back();
      logic [RW-1:0] expV;
      int            lat;
      logic          rdyLow;
      expV = mk(88, 77, 66, 55, 44, 33, 22, 11);
      issueCmd(vecA, vecB, 1'b0, OP_ADD);
      waitRsp(lat, rdyLow);
      bus.cmd_a       = vecA;
      bus.cmd_b       = mk(1, 2, 3, 4, 5, 6, 99, 7);
      bus.cmd_use_imm = 1'b1;
      bus.cmd_op      = OP_REPL;
      bus.cmd_valid   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         nCompared++; if (bus.rsp_result !== expV) begin nMismatched++; $display("[TB] FAIL hold_result[%0d]: got %h expected %h", k, bus.rsp_result, expV); end
         nCompared++; if (bus.cmd_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL hold_ready[%0d]: got %b expected 0", k, bus.cmd_ready); end
         nCompared++; if (bus.rsp_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL hold_valid[%0d]: got %b expected 1", k, bus.rsp_valid); end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      #1;
      nCompared++; if (bus.cmd_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_ready: got %b expected 1", bus.cmd_ready); end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      nCompared++; if (bus.rsp_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_valid: got %b expected 1", bus.rsp_valid); end
      nCompared++; if (bus.rsp_result !== splat(7)) begin nMismatched++; $display("[TB] FAIL b2b_result: got %h expected %h", bus.rsp_result, splat(7)); end
      retire();
   endtask

   task automatic test_reset_inflight();
      logic [RW-1:0] expV;
      int            lat;
      logic          rdyLow;
      logic          sawValid;
      issueCmd(vecA, vecB, 1'b0, OP_MUL);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL midmul_busy: got %b expected 0", bus.busy); end
      nCompared++; if (bus.rsp_result !== '0) begin nMismatched++; $display("[TB] FAIL midmul_result: got %h expected 0", bus.rsp_result); end
      nCompared++; if (bus.rsp_zero !== 1'b1) begin nMismatched++; $display("[TB] FAIL midmul_zero: got %b expected 1", bus.rsp_zero); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      nCompared++; if (bus.cmd_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL midmul_ready: got %b expected 1", bus.cmd_ready); end
      sawValid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid !== 1'b0) sawValid = 1'b1;
      end
      nCompared++; if (sawValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL midmul_no_rsp: got %b expected 0", sawValid); end
      expV = mk(88, 77, 66, 55, 44, 33, 22, 11);
      issueCmd(vecA, vecB, 1'b0, OP_ADD);
      waitRsp(lat, rdyLow);
      nCompared++; if (lat !== 1) begin nMismatched++; $display("[TB] FAIL postrst_latency: got %0d expected 1", lat); end
      nCompared++; if (bus.rsp_result !== expV) begin nMismatched++; $display("[TB] FAIL postrst_result: got %h expected %h", bus.rsp_result, expV); end
      // Reset while a response is pending must drop it as well
      rst = 1'b1;
      #1;
      nCompared++; if (bus.rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL resp_rst_valid: got %b expected 0", bus.rsp_valid); end
      @(negedge clk);
      rst = 1'b0;
      sawValid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid !== 1'b0) sawValid = 1'b1;
      end
      nCompared++; if (sawValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL resp_rst_no_rsp: got %b expected 0", sawValid); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.cmd_valid   = 1'b0;
      bus.cmd_a       = '0;
      bus.cmd_b       = '0;
      bus.cmd_use_imm = 1'b0;
      bus.cmd_op      = OP_ADD;
      bus.rsp_ready   = 1'b0;
      vecA = mk(80, 70, 60, 50, 40, 30, 20, 10);
      vecB = mk(8, 7, 6, 5, 4, 3, 2, 1);

      test_reset();
      test_add();
      test_mul();
      test_sub_imm();
      test_wrap();
      test_repl_reserved();
      test_back_to_back();
      test_reset_inflight();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
